// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC core.
// Every instruction takes four clocks: FETCH, LOAD, DECODE, EXEC.
// It owns the program counter and the instruction register. It drives
// the instruction-memory address, enable and halt inputs. It issues
// one-hot strobes to the accumulator/ALU and the data memory.
//
// Optional feature macro: SINGLE_STEP_EN
//   When this macro is defined, the block gains an input 'step' and a
//   STEP_WAIT state. The sequencer pauses there after every non-HLT
//   instruction and waits for step before the next fetch.
//
// Ports:
//   clk        in   system clock, all state changes on posedge
//   rst        in   synchronous active-high reset, highest priority
//   start      in   leaves IDLE and begins fetching at pc
//   step       in   (SINGLE_STEP_EN only) releases STEP_WAIT
//   imem_data  in   instruction word, valid the cycle after imem_en
//   acc_zero   in   accumulator == 0, used by SKZ in EXEC
//   imem_addr  out  instruction-memory address (= pc)
//   imem_en    out  fetch strobe
//   imem_halt  out  halt pulse to the instruction memory
//   ir         out  instruction register
//   pc         out  program counter
//   alu_op     out  opcode field of ir
//   data_addr  out  operand field of ir
//   data_rd    out  data-memory read strobe (ADD/AND/XOR/LDA in DECODE)
//   data_wr    out  data-memory write strobe (STO in EXEC)
//   acc_ld     out  accumulator load (ADD/AND/XOR/LDA in EXEC)
//   halted     out  core stopped after HLT
//   busy       out  state is neither IDLE nor HALTED
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  acc_zero,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_en,
    output logic                  imem_halt,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [2:0]            alu_op,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  data_rd,
    output logic                  data_wr,
    output logic                  acc_ld,
    output logic                  halted,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        DECODE,
        EXEC,
`ifdef SINGLE_STEP_EN
        STEP_WAIT,
`endif
        HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_t;

    state_t                  state;
    state_t                  state_n;
    opcode_t                 op;
    logic                    reads_mem;
    logic [ADDR_WIDTH-1:0]   pc_n;

    assign op        = opcode_t'(ir[DATA_WIDTH-1 -: 3]);
    assign alu_op    = ir[DATA_WIDTH-1 -: 3];
    assign data_addr = ir[ADDR_WIDTH-1:0];
    assign imem_addr = pc;
    assign halted    = (state == HALTED);
    assign busy      = (state != IDLE) && (state != HALTED);

    // These opcodes need a data-memory operand. The operand is read in
    // DECODE so that the one-cycle read latency lands it for EXEC.
    assign reads_mem = (op == OP_ADD) || (op == OP_AND) ||
                       (op == OP_XOR) || (op == OP_LDA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_n;
            if (state == LOAD) begin
                ir <= imem_data;
            end
            if (state == EXEC) begin
                pc <= pc_n;
            end
        end
    end

    // The pc update wraps modulo 2^ADDR_WIDTH through the natural
    // overflow of the fixed-width addition.
    always_comb begin
        pc_n = pc + ADDR_WIDTH'(1);
        unique case (op)
            OP_JMP:  pc_n = ir[ADDR_WIDTH-1:0];
            OP_SKZ:  pc_n = acc_zero ? pc + ADDR_WIDTH'(2) : pc + ADDR_WIDTH'(1);
            OP_HLT:  pc_n = pc;
            default: pc_n = pc + ADDR_WIDTH'(1);
        endcase
    end

    always_comb begin
        state_n   = state;
        imem_en   = 1'b0;
        imem_halt = 1'b0;
        data_rd   = 1'b0;
        data_wr   = 1'b0;
        acc_ld    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                imem_en = 1'b1;
                state_n = LOAD;
            end
            LOAD: begin
                state_n = DECODE;
            end
            DECODE: begin
                data_rd = reads_mem;
                state_n = EXEC;
            end
            EXEC: begin
                acc_ld    = reads_mem;
                data_wr   = (op == OP_STO);
                imem_halt = (op == OP_HLT);
                if (op == OP_HLT) begin
                    state_n = HALTED;
                end else begin
`ifdef SINGLE_STEP_EN
                    state_n = STEP_WAIT;
`else
                    state_n = FETCH;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            STEP_WAIT: begin
                if (step) begin
                    state_n = FETCH;
                end
            end
`endif
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. The bench holds a 32 x 8
// instruction memory with a registered read. An instruction-level
// reference model predicts the per-phase strobes and the next pc from
// the opcode rules, using integer arithmetic modulo 32.
module tb_fetch_sequencer;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
`ifdef SINGLE_STEP_EN
    logic          step;
`endif
    logic [DW-1:0] imem_data;
    logic          acc_zero;
    logic [AW-1:0] imem_addr;
    logic          imem_en;
    logic          imem_halt;
    logic [DW-1:0] ir;
    logic [AW-1:0] pc;
    logic [2:0]    alu_op;
    logic [AW-1:0] data_addr;
    logic          data_rd;
    logic          data_wr;
    logic          acc_ld;
    logic          halted;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int m_pc    = 0;

    logic [7:0] mem [32];

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .imem_data (imem_data),
        .acc_zero  (acc_zero),
        .imem_addr (imem_addr),
        .imem_en   (imem_en),
        .imem_halt (imem_halt),
        .ir        (ir),
        .pc        (pc),
        .alu_op    (alu_op),
        .data_addr (data_addr),
        .data_rd   (data_rd),
        .data_wr   (data_wr),
        .acc_ld    (acc_ld),
        .halted    (halted),
        .busy      (busy)
    );

    // Instruction memory: one-cycle registered read, output frozen by halt.
    always @(posedge clk) begin
        if (rst) imem_data <= '0;
        else if (imem_en && !imem_halt) imem_data <= mem[imem_addr];
    end

    function automatic logic [4:0] strobes();
        return {imem_en, imem_halt, data_rd, data_wr, acc_ld};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_ir"}, 32'(ir), 32'd0);
        check({tag, "_str"}, 32'(strobes()), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pc = 0;
    endtask

    // From IDLE: pulse start, then the DUT sits in FETCH.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs one instruction from FETCH. On return the DUT is in FETCH of
    // the next instruction, or in HALTED when the instruction was HLT.
    task automatic run_instr(input logic az, output logic was_hlt);
        logic [7:0] ins;
        logic [2:0] op;
        logic [4:0] exp_str;
        int         nxt;
        ins = mem[m_pc];
        op  = ins[7:5];
        check("fetch_str", 32'(strobes()), 32'b10000);
        check("fetch_addr", 32'(imem_addr), 32'(m_pc));
        check("fetch_busy", 32'(busy), 32'd1);
        tick();
        check("load_str", 32'(strobes()), 32'd0);
        tick();
        check("dec_ir", 32'(ir), 32'(ins));
        check("dec_aluop", 32'(alu_op), 32'(op));
        check("dec_daddr", 32'(data_addr), 32'(ins[4:0]));
        check("dec_str", 32'(strobes()),
              (op inside {3'd2, 3'd3, 3'd4, 3'd5}) ? 32'b00100 : 32'd0);
        acc_zero = az;
        tick();
        if (op == 3'd0)      exp_str = 5'b01000;
        else if (op == 3'd6) exp_str = 5'b00010;
        else if (op == 3'd1 || op == 3'd7) exp_str = 5'b00000;
        else                 exp_str = 5'b00001;
        check("exec_str", 32'(strobes()), 32'(exp_str));
        check("exec_daddr", 32'(data_addr), 32'(ins[4:0]));
        if (op == 3'd7)      nxt = int'(ins[4:0]);
        else if (op == 3'd1) nxt = az ? (m_pc + 2) % 32 : (m_pc + 1) % 32;
        else if (op == 3'd0) nxt = m_pc;
        else                 nxt = (m_pc + 1) % 32;
        tick();
        was_hlt = (op == 3'd0);
        if (was_hlt) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_busy", 32'(busy), 32'd0);
            check("halt_str", 32'(strobes()), 32'd0);
        end else begin
`ifdef SINGLE_STEP_EN
            for (int w = 0; w < 2; w++) begin
                check("stepw_str", 32'(strobes()), 32'd0);
                check("stepw_busy", 32'(busy), 32'd1);
                tick();
            end
            step = 1'b1;
            check("stepw_str", 32'(strobes()), 32'd0);
            tick();
            step = 1'b0;
`endif
        end
        check("next_pc", 32'(pc), 32'(nxt));
        m_pc = nxt;
    endtask

    task automatic run_prog(input int max_instr, input int az_mode, output logic hit_hlt);
        logic h;
        logic az;
        hit_hlt = 1'b0;
        for (int k = 0; k < max_instr && !hit_hlt; k++) begin
            az = (az_mode == 2) ? logic'($urandom_range(1, 0)) : logic'(az_mode);
            run_instr(az, h);
            hit_hlt = h;
        end
    endtask

    initial begin
        logic h;
        rst = 1'b0;
        start = 1'b0;
        acc_zero = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

        // Reset state, and IDLE holds without start.
        do_reset();
        check_reset_state("rst");
        tick();
        check("idle_hold_busy", 32'(busy), 32'd0);

        // LDA 3, ADD 4, STO 5, HLT
        mem[0] = 8'hA3; mem[1] = 8'h44; mem[2] = 8'hC5; mem[3] = 8'h00;
        do_start();
        run_prog(8, 2, h);
        check("prog1_halt", 32'(h), 32'd1);
        check("prog1_pc", 32'(pc), 32'd3);

        // HALTED ignores start.
        for (int i = 0; i < 4; i++) begin
            start = 1'(i % 2 == 0);
            tick();
            check("hlt_stay", 32'(halted), 32'd1);
            check("hlt_str", 32'(strobes()), 32'd0);
            check("hlt_pc", 32'(pc), 32'd3);
        end
        start = 1'b0;
        do_reset();
        check_reset_state("hlt_rst");

        // JMP 28, then HLT at 28.
        mem[0] = 8'hFC; mem[28] = 8'h00;
        do_start();
        run_prog(4, 0, h);
        check("jmp_pc", 32'(pc), 32'd28);
        do_reset();

        // SKZ at 31, taken: pc wraps to 1.
        mem[0] = 8'hFF; mem[31] = 8'h20; mem[1] = 8'h00; mem[0] = 8'hFF;
        do_start();
        run_prog(4, 1, h);
        check("skz_taken_pc", 32'(pc), 32'd1);
        do_reset();

        // SKZ at 31, not taken: pc wraps to 0, which holds JMP 31 again.
        do_start();
        run_prog(2, 0, h);
        check("skz_wrap_pc", 32'(pc), 32'd0);
        do_reset();

        // Reset during DECODE of ADD 7: no acc_ld may ever appear.
        mem[0] = 8'h47; mem[1] = 8'h00;
        do_start();
        tick();
        tick();
        check("rd_dec_str", 32'(strobes()), 32'b00100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pc = 0;
        check_reset_state("rst_dec");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_dec_noacc", 32'(strobes()), 32'd0);
        end
        do_start();
        run_prog(4, 0, h);
        check("rst_dec_restart", 32'(h), 32'd1);
        do_reset();

        // Random programs, bounded in length, with random acc_zero.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
            do_start();
            run_prog(30, 2, h);
            do_reset();
            check_reset_state("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
